inst_fetch: RTL and testbench

Front-end fetch unit. It generates PCs, issues reads on the instruction SRAM-like request/response interface, and buffers returned words with their PCs. It presents instructions to the decode Control stage through a valid/ready handshake. It also accepts redirects (taken branch, jirl, exception, ertn), flushes its buffered and in-flight fetches, and flags misaligned-PC fetch faults (ADEF).

---
 rtl/inst_fetch_pkg.sv | 29 ++
 rtl/inst_fetch_fifo.sv | 84 ++++++++
 rtl/inst_fetch.sv | 169 ++++++++++++++++
 tb/tb_inst_fetch.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_pkg
// Description : Shared types and constants for the instruction fetch unit:
//               reset PC default, NOP encoding, buffered fetch entry and the
//               fetch state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1C00_0000;
  // Filler word carried by an ADEF entry so decode sees a harmless op.
  localparam logic [31:0] NOP_INSTR        = 32'h0340_0000;

  typedef logic [31:0] Instr;

  typedef struct packed {
    logic [31:0] pc;
    Instr        instr;
    logic        adef;
  } FetchEntry;

  typedef enum logic [0:0] {
    F_RUN  = 1'b0,
    F_HALT = 1'b1
  } FetchState;

endpackage : inst_fetch_pkg
`default_nettype wire

// File: rtl/inst_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Generic synchronous FIFO with flush and occupancy count.
//               Ports: clk, resetn (async active-low), flush (clears contents),
//               push/push_data, pop/pop_data (head, valid when !empty),
//               full, empty, count.
//               A push while full is honoured only if a pop happens too.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [AW-1:0]    w_wr_ptr_nxt;
  logic [AW-1:0]    w_rd_ptr_nxt;
  logic             w_push;
  logic             w_pop;

  assign full     = (r_count == CW'(DEPTH));
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign pop_data = r_mem[r_rd_ptr];

  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  // Power-of-two depth lets pointers wrap naturally; a single entry never moves.
  generate
    if (DEPTH > 1) begin : g_ptr_wrap
      assign w_wr_ptr_nxt = r_wr_ptr + 1'b1;
      assign w_rd_ptr_nxt = r_rd_ptr + 1'b1;
    end else begin : g_ptr_single
      assign w_wr_ptr_nxt = '0;
      assign w_rd_ptr_nxt = '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= w_wr_ptr_nxt;
      if (w_pop)  r_rd_ptr <= w_rd_ptr_nxt;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once counted as valid.
  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= push_data;
  end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch
// Description : Front-end fetch unit. Generates PCs, issues reads on the
//               instruction SRAM request/response interface, buffers returned
//               words with their PCs and hands them to decode by valid/ready.
//               Redirects flush buffered and in-flight fetches; a misaligned
//               PC produces a single ADEF entry and halts fetch.
//   Ports: clk, resetn (async active-low)
//          inst_sram_req/addr/addr_ok/data_ok/rdata : SRAM-like fetch port
//          redirect_valid/redirect_pc               : flush and restart
//          if_valid/id_ready/if_instr/if_pc/if_adef : decode handshake
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int          IBUF_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        id_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_adef
);

  localparam int OCW = $clog2(IBUF_DEPTH) + 1;
  localparam int ICW = $clog2(MAX_OUTSTANDING) + 1;

  FetchState      r_state;
  FetchState      w_state_nxt;
  logic [31:0]    r_pc;
  logic [ICW-1:0] r_discard;
  logic           r_started;

  logic           w_pend_full;
  logic           w_pend_empty;
  logic [ICW-1:0] w_inflight;
  logic [31:0]    w_pend_head;

  logic           w_buf_full;
  logic           w_buf_empty;
  logic [OCW-1:0] w_occ;
  FetchEntry      w_head;
  FetchEntry      w_buf_wdata;
  logic           w_buf_push;
  logic           w_buf_pop;

  logic [31:0]    w_live;
  logic           w_accept;
  logic           w_resp;
  logic           w_resp_keep;
  logic           w_adef;

  // Occupancy plus every in-flight word that will still land; discards are
  // subtracted because they never take a buffer slot.
  assign w_live = 32'(w_occ) + 32'(w_inflight) - 32'(r_discard);

  // r_started keeps req low while reset is asserted and for the first edge.
  assign inst_sram_req  = r_started && (r_state == F_RUN) && (r_pc[1:0] == 2'b00)
                       && !redirect_valid && !w_pend_full
                       && (w_live < 32'(IBUF_DEPTH));
  assign inst_sram_addr = r_pc;

  assign w_accept    = inst_sram_req && inst_sram_addr_ok;
  assign w_resp      = inst_sram_data_ok && !w_pend_empty;
  assign w_resp_keep = w_resp && (r_discard == '0);

  // Only fault once every live word has landed so the ADEF entry is ordered
  // after them. Since inflight==discard here, no kept response collides.
  assign w_adef = (r_state == F_RUN) && (r_pc[1:0] != 2'b00)
               && (w_inflight == r_discard) && !w_buf_full;

  always_comb begin
    w_buf_wdata = '0;
    if (w_adef) begin
      w_buf_wdata.pc    = r_pc;
      w_buf_wdata.instr = NOP_INSTR;
      w_buf_wdata.adef  = 1'b1;
    end else begin
      w_buf_wdata.pc    = w_pend_head;
      w_buf_wdata.instr = inst_sram_rdata;
      w_buf_wdata.adef  = 1'b0;
    end
  end

  assign w_buf_push = !redirect_valid && (w_resp_keep || w_adef);
  assign w_buf_pop  = !redirect_valid && if_valid && id_ready;

  sync_fifo #(
    .WIDTH ($bits(FetchEntry)),
    .DEPTH (IBUF_DEPTH)
  ) u_ibuf (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (redirect_valid),
    .push      (w_buf_push),
    .push_data (w_buf_wdata),
    .pop       (w_buf_pop),
    .pop_data  (w_head),
    .full      (w_buf_full),
    .empty     (w_buf_empty),
    .count     (w_occ)
  );

  // Pending-PC queue: its occupancy is the in-flight request count.
  sync_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pend_pc (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (1'b0),
    .push      (w_accept),
    .push_data (r_pc),
    .pop       (w_resp),
    .pop_data  (w_pend_head),
    .full      (w_pend_full),
    .empty     (w_pend_empty),
    .count     (w_inflight)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= F_RUN;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (redirect_valid)  w_state_nxt = F_RUN;
    else if (w_adef)     w_state_nxt = F_HALT;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pc      <= RESET_PC;
      r_discard <= '0;
      r_started <= 1'b0;
    end else begin
      r_started <= 1'b1;
      if (redirect_valid)  r_pc <= redirect_pc;
      else if (w_accept)   r_pc <= r_pc + 32'd4;

      // Everything still outstanding after this edge belongs to the old path.
      if (redirect_valid)
        r_discard <= w_inflight - (w_resp ? ICW'(1) : ICW'(0));
      else if (w_resp && (r_discard != '0))
        r_discard <= r_discard - 1'b1;
    end
  end

  assign if_valid = !w_buf_empty;
  assign if_instr = if_valid ? w_head.instr : 32'h0;
  assign if_pc    = if_valid ? w_head.pc    : 32'h0;
  assign if_adef  = if_valid && w_head.adef;

endmodule : inst_fetch
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch
// Description : Self-checking bench for inst_fetch. A randomised SRAM model
//               answers requests in order; a stream-level reference predicts
//               the request address sequence and the decode entry sequence
//               (PC, word, fault flag) from the last redirect target.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

  localparam logic [31:0] RST_PC  = 32'h1C00_0000;
  localparam logic [31:0] NOP     = 32'h0340_0000;
  localparam int          MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        id_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_adef;

  always #5 clk = ~clk;

  inst_fetch #(
    .RESET_PC        (RST_PC),
    .IBUF_DEPTH      (4),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk               (clk),
    .resetn            (resetn),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .if_valid          (if_valid),
    .id_ready          (id_ready),
    .if_instr          (if_instr),
    .if_pc             (if_pc),
    .if_adef           (if_adef)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Stimulus knobs (percent probability per cycle).
  int aok_pct, dok_pct, rdy_pct;

  // Memory model and stream reference.
  logic [31:0] mem_q[$];
  logic [31:0] exp_req_pc;
  logic [31:0] exp_pc;
  bit          exp_done;
  bit          redir_prev;
  bit          last_req;
  int          n_pops, n_acc, n_adef;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] + 16'h1357};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_restart(input logic [31:0] target);
    exp_req_pc = target;
    exp_pc     = target;
    exp_done   = 1'b0;
  endtask

  // One clock: drive at negedge, observe 1 time unit later, then update the
  // models after the rising edge.
  task automatic cycle(input bit redir, input logic [31:0] rpc);
    bit          acc, dok;
    logic [31:0] addr;
    @(negedge clk);
    inst_sram_addr_ok = ($urandom_range(99) < aok_pct);
    dok = (mem_q.size() > 0) && ($urandom_range(99) < dok_pct);
    inst_sram_data_ok = dok;
    inst_sram_rdata   = dok ? instr_of(mem_q[0]) : $urandom;
    id_ready          = ($urandom_range(99) < rdy_pct);
    redirect_valid    = redir;
    redirect_pc       = rpc;
    #1;
    addr     = inst_sram_addr;
    acc      = inst_sram_req && inst_sram_addr_ok;
    last_req = inst_sram_req;
    if (redir_prev) check_eq("valid_after_redirect", {31'b0, if_valid}, 32'd0);
    if (redir) check_eq("req_during_redirect", {31'b0, inst_sram_req}, 32'd0);
    if (exp_req_pc[1:0] != 2'b00) check_eq("req_while_misaligned", {31'b0, inst_sram_req}, 32'd0);
    if (inst_sram_req) check_eq("req_addr", addr, exp_req_pc);
    if (acc) check_eq("outstanding_room", {31'b0, mem_q.size() < MAX_OUT}, 32'd1);
    if (if_valid && id_ready && !redir) begin
      n_pops++;
      if (exp_done) begin
        check_eq("entry_after_adef", {31'b0, if_valid}, 32'd0);
      end else if (exp_pc[1:0] != 2'b00) begin
        check_eq("adef_pc", if_pc, exp_pc);
        check_eq("adef_instr", if_instr, NOP);
        check_eq("adef_flag", {31'b0, if_adef}, 32'd1);
        exp_done = 1'b1;
        n_adef++;
      end else begin
        check_eq("entry_pc", if_pc, exp_pc);
        check_eq("entry_instr", if_instr, instr_of(exp_pc));
        check_eq("entry_adef", {31'b0, if_adef}, 32'd0);
        exp_pc = exp_pc + 32'd4;
      end
    end
    @(posedge clk);
    if (dok) void'(mem_q.pop_front());
    if (acc) begin
      mem_q.push_back(addr);
      exp_req_pc = exp_req_pc + 32'd4;
      n_acc++;
    end
    if (redir) model_restart(rpc);
    redir_prev = redir;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0);
  endtask

  task automatic drive_idle();
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata   = 32'h0;
    redirect_valid    = 1'b0;
    redirect_pc       = 32'h0;
    id_ready          = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_req",   {31'b0, inst_sram_req}, 32'd0);
    check_eq("rst_valid", {31'b0, if_valid}, 32'd0);
    check_eq("rst_adef",  {31'b0, if_adef}, 32'd0);
    check_eq("rst_instr", if_instr, 32'd0);
    check_eq("rst_pc",    if_pc, 32'd0);
  endtask

  // Asserts reset in the middle of a clock phase to exercise the async path.
  task automatic do_reset();
    @(posedge clk);
    #2;
    resetn = 1'b0;
    drive_idle();
    #1;
    check_reset_outputs();
    mem_q.delete();
    model_restart(RST_PC);
    redir_prev = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic wait_inflight(input int n, input string tag);
    int budget = 20;
    while (mem_q.size() < n && budget > 0) begin
      cycle(1'b0, 32'h0);
      budget--;
    end
    check_eq(tag, mem_q.size(), n);
  endtask

  initial begin
    int p0, a0, d0;
    logic [31:0] tgt;
    resetn = 1'b0;
    drive_idle();
    mem_q.delete();
    model_restart(RST_PC);
    redir_prev = 1'b0;
    n_pops = 0; n_acc = 0; n_adef = 0;
    #1;
    check_reset_outputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Streaming with a fully ready memory and decode.
    aok_pct = 100; dok_pct = 100; rdy_pct = 100;
    p0 = n_pops;
    run(12);
    check_eq("stream_pops", {31'b0, (n_pops - p0) >= 3}, 32'd1);

    // Decode stalled: buffer plus reservations cap the accepted requests.
    do_reset();
    rdy_pct = 0;
    a0 = n_acc;
    run(20);
    check_eq("stall_accepts", n_acc - a0, 32'd4);
    check_eq("stall_req_low", {31'b0, last_req}, 32'd0);
    rdy_pct = 100;
    p0 = n_pops;
    run(10);
    check_eq("stall_drain", {31'b0, (n_pops - p0) >= 4}, 32'd1);

    // Redirect while two requests are outstanding.
    do_reset();
    dok_pct = 0;
    wait_inflight(2, "two_inflight");
    cycle(1'b1, 32'h1C00_0100);
    dok_pct = 100;
    p0 = n_pops;
    run(15);
    check_eq("redirect_pops", {31'b0, (n_pops - p0) > 0}, 32'd1);

    // Redirect in the same cycle a response returns.
    rdy_pct = 50;
    wait_inflight(1, "one_inflight");
    cycle(1'b1, 32'h1C00_0300);
    rdy_pct = 100;
    p0 = n_pops;
    run(15);
    check_eq("redir_dataok_pops", {31'b0, (n_pops - p0) > 0}, 32'd1);

    // Misaligned redirect: one ADEF entry, then halt until redirected.
    d0 = n_adef;
    cycle(1'b1, 32'h1C00_0102);
    run(20);
    check_eq("adef_count", n_adef - d0, 32'd1);
    p0 = n_pops;
    cycle(1'b1, 32'h1C00_0200);
    run(15);
    check_eq("resume_pops", {31'b0, (n_pops - p0) > 0}, 32'd1);

    // PC wrap past the top of the address space.
    cycle(1'b1, 32'hFFFF_FFF8);
    run(15);

    // Reset with two requests outstanding; old responses are forgotten.
    dok_pct = 0;
    wait_inflight(2, "two_inflight_rst");
    do_reset();
    dok_pct = 100;
    p0 = n_pops;
    run(10);
    check_eq("post_reset_pops", {31'b0, (n_pops - p0) > 0}, 32'd1);

    // Randomised traffic with occasional (possibly back-to-back) redirects.
    aok_pct = 60; dok_pct = 50; rdy_pct = 60;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(99) < 3) begin
        tgt = 32'h1C00_0000 + ($urandom_range(255) << 2);
        if ($urandom_range(9) == 0) tgt[1:0] = 2'($urandom_range(3, 1));
        cycle(1'b1, tgt);
      end else begin
        cycle(1'b0, 32'h0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_inst_fetch
`default_nettype wire
